// File: rtl/wwd_display_scan.sv
// Display-side capture of the CPU output port: history ring, 4-digit 7-segment scan, PC LEDs.
// Define DISP_HISTORY_EN to build the HIST_DEPTH-entry ring with history_step browsing.
module wwd_display_scan #(
  parameter int SCAN_DIV   = 16,
  parameter int HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_cpu,
  input  logic [15:0]                   output_port,
  input  logic [7:0]                    PC_below8bit,
  input  logic                          history_step,
  output logic [6:0]                    seg_out,
  output logic [3:0]                    digit_sel,
  output logic [7:0]                    led_out,
  output logic [$clog2(HIST_DEPTH)-1:0] hist_index
);

  localparam int IW = $clog2(HIST_DEPTH);
  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [6:0]    seg_out_q, seg_out_d;
  logic [3:0]    digit_sel_q, digit_sel_d;
  logic [7:0]    led_out_q, led_out_d;
  logic [15:0]   shown_value;
  logic          shown_valid;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

`ifdef DISP_HISTORY_EN
  localparam int CW = IW + 1;

  logic [15:0]   hist_q [HIST_DEPTH];
  logic [15:0]   hist_d [HIST_DEPTH];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic          capture;

  assign capture = (count_q == '0) || (output_port != hist_q[head_q]);

  // A capture always wins over a simultaneous step and snaps the view back to the newest entry.
  always_comb begin
    hist_d  = hist_q;
    head_d  = head_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (capture) begin
      head_d         = head_q + 1'b1;
      hist_d[head_d] = output_port;
      if (count_q != CW'(HIST_DEPTH)) count_d = count_q + 1'b1;
      idx_d = '0;
    end else if (history_step && (count_q > CW'(1))) begin
      idx_d = ((CW'(idx_q) + 1'b1) == count_q) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      head_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      head_q  <= head_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign shown_value = hist_q[head_q - idx_q];
  assign shown_valid = (count_q != '0);
  assign hist_index  = idx_q;
`else
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        unused_history_step;

  assign unused_history_step = history_step;

  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    if (!valid_q || (output_port != value_q)) begin
      value_d = output_port;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign shown_value = value_q;
  assign shown_valid = valid_q;
  assign hist_index  = '0;
`endif

  // Segments are looked up for the digit that becomes active on this edge so select and data switch together.
  always_comb begin
    div_d = div_q + 1'b1;
    ptr_d = ptr_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      ptr_d = ptr_q + 1'b1;
    end
    nibble      = shown_value[{ptr_d, 2'b00} +: 4];
    seg_out_d   = shown_valid ? hex_font(nibble) : 7'h7F;
    digit_sel_d = ~(4'b0001 << ptr_d);
    led_out_d   = PC_below8bit;
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      div_q       <= '0;
      ptr_q       <= '0;
      seg_out_q   <= 7'h7F;
      digit_sel_q <= 4'b1110;
      led_out_q   <= '0;
    end else begin
      div_q       <= div_d;
      ptr_q       <= ptr_d;
      seg_out_q   <= seg_out_d;
      digit_sel_q <= digit_sel_d;
      led_out_q   <= led_out_d;
    end
  end

  assign seg_out   = seg_out_q;
  assign digit_sel = digit_sel_q;
  assign led_out   = led_out_q;

endmodule

// File: tb/tb_wwd_display_scan.sv
// Directed bench for wwd_display_scan; ring browsing steps run only when DISP_HISTORY_EN is defined.
module tb_wwd_display_scan;

  localparam int SD = 4;
  localparam int HD = 4;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic [15:0] output_port;
  logic [7:0]  pc;
  logic        history_step;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;
  logic [7:0]  led_out;
  logic [1:0]  hist_index;

  int checks = 0;
  int errors = 0;
  int mdiv = 0;
  int mptr = 0;
  logic [6:0]  font [16];
  logic [15:0] older [4];

  always #5 clk = ~clk;

  wwd_display_scan #(.SCAN_DIV(SD), .HIST_DEPTH(HD)) dut (
    .clk(clk),
    .reset_cpu(reset_cpu),
    .output_port(output_port),
    .PC_below8bit(pc),
    .history_step(history_step),
    .seg_out(seg_out),
    .digit_sel(digit_sel),
    .led_out(led_out),
    .hist_index(hist_index)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent scan-phase model advanced on every rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset_cpu) begin
      mdiv = 0;
      mptr = 0;
    end else if (mdiv == SD - 1) begin
      mdiv = 0;
      mptr = (mptr + 1) % 4;
    end else begin
      mdiv++;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    output_port = v;
    tick();
  endtask

  task automatic stepPulse();
    history_step = 1'b1;
    tick();
    history_step = 1'b0;
  endtask

  task automatic checkDisplay(input logic [15:0] v, input string tag);
    logic [3:0] exp_sel;
    for (int i = 0; i < 4 * SD; i++) begin
      exp_sel = ~(4'b0001 << mptr);
      checkOutput({tag, "_sel"}, {12'h0, digit_sel}, {12'h0, exp_sel});
      checkOutput({tag, "_seg"}, {9'h0, seg_out}, {9'h0, font[v[4*mptr +: 4]]});
      tick();
    end
  endtask

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    older = '{16'h0004, 16'h0300, 16'h0200, 16'h0100};
    reset_cpu    = 1'b1;
    output_port  = 16'h0000;
    pc           = 8'h00;
    history_step = 1'b0;

    tick();
    tick();
    checkOutput("rst_seg", {9'h0, seg_out}, 16'h007F);
    checkOutput("rst_sel", {12'h0, digit_sel}, 16'h000E);
    checkOutput("rst_led", {8'h0, led_out}, 16'h0000);
    checkOutput("rst_idx", {14'h0, hist_index}, 16'h0000);

    reset_cpu = 1'b0;
    tick();
    checkOutput("empty_seg", {9'h0, seg_out}, 16'h007F);
    tick();
    checkOutput("first_seg", {9'h0, seg_out}, 16'h0040);
    checkOutput("first_sel", {12'h0, digit_sel}, 16'h000E);

    $display("[TB] hold 0300 and verify scan order");
    applyStimulus(16'h0300);
    tick();
    for (int i = 0; i < 4 * SD && !(mptr == 0 && mdiv == 0); i++) tick();
    checkDisplay(16'h0300, "hold_a");
    checkDisplay(16'h0300, "hold_b");

`ifdef DISP_HISTORY_EN
    $display("[TB] history browsing");
    stepPulse();
    checkOutput("cnt2_idx1", {14'h0, hist_index}, 16'h0001);
    tick();
    checkDisplay(16'h0000, "cnt2_old");
    stepPulse();
    checkOutput("cnt2_wrap", {14'h0, hist_index}, 16'h0000);
    tick();
    checkDisplay(16'h0300, "cnt2_new");

    applyStimulus(16'h0000);
    applyStimulus(16'h0100);
    applyStimulus(16'h0200);
    applyStimulus(16'h0300);
    applyStimulus(16'h0004);
    tick();
    checkDisplay(16'h0004, "newest");
    for (int k = 1; k < 4; k++) begin
      stepPulse();
      checkOutput("step_idx", {14'h0, hist_index}, 16'(k));
      tick();
      checkDisplay(older[k], "step_val");
    end
    stepPulse();
    checkOutput("full_wrap_idx", {14'h0, hist_index}, 16'h0000);
    tick();
    checkDisplay(16'h0004, "full_wrap_val");
    stepPulse();
    checkOutput("pre_race_idx", {14'h0, hist_index}, 16'h0001);
`else
    $display("[TB] single-register build");
    applyStimulus(16'h0100);
    applyStimulus(16'h0200);
    stepPulse();
    checkOutput("nohist_idx", {14'h0, hist_index}, 16'h0000);
    tick();
    checkDisplay(16'h0200, "nohist_val");
`endif

    $display("[TB] capture and step in the same cycle");
    output_port  = 16'h00FC;
    history_step = 1'b1;
    tick();
    history_step = 1'b0;
    checkOutput("race_idx", {14'h0, hist_index}, 16'h0000);
    tick();
    checkDisplay(16'h00FC, "race_val");

    $display("[TB] PC mirror");
    pc = 8'h10;
    tick();
    checkOutput("led_10", {8'h0, led_out}, 16'h0010);
    for (int v = 8'h11; v <= 8'h15; v++) begin
      pc = 8'(v);
      checkOutput("led_hold", {8'h0, led_out}, 16'(v - 1));
      tick();
      checkOutput("led_next", {8'h0, led_out}, 16'(v));
    end

    $display("[TB] reset on digit 2");
    for (int i = 0; i < 4 * SD && mptr != 2; i++) tick();
    checkOutput("pre_rst_sel", {12'h0, digit_sel}, 16'h000B);
    reset_cpu = 1'b1;
    tick();
    checkOutput("mid_rst_sel", {12'h0, digit_sel}, 16'h000E);
    checkOutput("mid_rst_seg", {9'h0, seg_out}, 16'h007F);
    checkOutput("mid_rst_led", {8'h0, led_out}, 16'h0000);
    checkOutput("mid_rst_idx", {14'h0, hist_index}, 16'h0000);
    reset_cpu = 1'b0;
    tick();
    checkOutput("post_rst_empty", {9'h0, seg_out}, 16'h007F);
    tick();
    checkDisplay(16'h00FC, "post_rst_val");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
